// File: rtl/prog_uart_pkg.sv
// ============================================================================
// prog_uart_pkg : shared types and constants for the program-load UART
// Revision 1.0
// ============================================================================
`default_nettype none

package prog_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int CPB_W          = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchronizer for a single asynchronous input bit
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

`default_nettype wire

// File: rtl/prog_uart_rx.sv
// ============================================================================
// prog_uart_rx : 8N1 UART receiver with run-time bit period, start-bit glitch
//                rejection and stop-bit framing check
// Revision 1.0
// ============================================================================
`default_nettype none

module prog_uart_rx #(
  parameter int CPB_W   = prog_uart_pkg::CPB_W,
  parameter int MIN_CPB = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic [CPB_W-1:0] clks_per_bit_i,
  output logic             rx_dv_o,
  output logic [7:0]       rx_byte_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  import prog_uart_pkg::*;

  localparam logic [CPB_W-1:0] C_MIN_CPB = CPB_W'(MIN_CPB);
  localparam logic [CPB_W-1:0] C_ONE     = CPB_W'(1);

  uart_rx_state_e            r_state;
  uart_rx_state_e            w_next_state;
  logic [CPB_W-1:0]          r_clk_cnt;
  logic [CPB_W-1:0]          r_cpb;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;

  logic             w_rx_s;
  logic [CPB_W-1:0] w_cpb_clamp;
  logic [CPB_W-1:0] w_last;
  logic [CPB_W-1:0] w_half;
  logic             w_mid_tick;
  logic             w_bit_tick;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (w_rx_s)
  );

  assign w_cpb_clamp = (clks_per_bit_i < C_MIN_CPB) ? C_MIN_CPB : clks_per_bit_i;
  assign w_last      = r_cpb - C_ONE;
  assign w_half      = w_last >> 1;
  assign w_mid_tick  = (r_clk_cnt == w_half);
  assign w_bit_tick  = (r_clk_cnt == w_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_rx_s) w_next_state = START;
      // A line back high at mid start bit was only a glitch.
      START:   if (w_mid_tick) w_next_state = w_rx_s ? IDLE : DATA;
      DATA:    if (w_bit_tick && (r_bit_idx == 3'd7)) w_next_state = STOP;
      STOP:    if (w_bit_tick) w_next_state = CLEANUP;
      CLEANUP: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_clk_cnt   <= '0;
      r_cpb       <= C_MIN_CPB;
      r_bit_idx   <= 3'd0;
      r_shift     <= '0;
      rx_dv_o     <= 1'b0;
      frame_err_o <= 1'b0;
      rx_byte_o   <= 8'h00;
    end else begin
      rx_dv_o     <= 1'b0;
      frame_err_o <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          // The bit period is frozen for the whole frame at its start edge.
          if (!w_rx_s) r_cpb <= w_cpb_clamp;
        end
        START: begin
          if (w_mid_tick) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
          end else begin
            r_clk_cnt <= r_clk_cnt + C_ONE;
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_clk_cnt          <= '0;
            r_bit_idx          <= (r_bit_idx == 3'd7) ? 3'd0 : r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + C_ONE;
          end
        end
        STOP: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              rx_byte_o <= r_shift;
              rx_dv_o   <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + C_ONE;
          end
        end
        CLEANUP: r_clk_cnt <= '0;
        default: r_clk_cnt <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_uart_rx.sv
// ============================================================================
// tb_prog_uart_rx : scoreboard testbench for prog_uart_rx
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_prog_uart_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } exp_t;

  logic        clk_i;
  logic        rst_ni;
  logic        rx_i;
  logic [15:0] clks_per_bit_i;
  logic        rx_dv_o;
  logic [7:0]  rx_byte_o;
  logic        frame_err_o;
  logic        busy_o;

  exp_t       sb[$];
  logic [7:0] rcv[$];
  int total;
  int bad;
  int dv_cnt;
  int err_cnt;

  prog_uart_rx #(
    .CPB_W   (16),
    .MIN_CPB (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rx_i           (rx_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_dv_o        (rx_dv_o),
    .rx_byte_o      (rx_byte_o),
    .frame_err_o    (frame_err_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  // Pops the scoreboard whenever the DUT emits a pulse; also guards byte stability.
  task automatic monitor();
    logic [7:0] last;
    exp_t e;
    last = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        last = rx_byte_o;
      end else begin
        if (rx_dv_o && frame_err_o) begin
          total++; bad++;
          $display("FAIL pulse_overlap: rx_dv_o and frame_err_o both high");
        end
        if (rx_dv_o) begin
          dv_cnt++;
          rcv.push_back(rx_byte_o);
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_dv: got byte %h, nothing expected", rx_byte_o);
          end else begin
            e = sb.pop_front();
            if (e.err !== 1'b0 || rx_byte_o !== e.b) begin
              bad++;
              $display("FAIL rx_byte: got dv byte %h, want err=%0b byte %h", rx_byte_o, e.err, e.b);
            end
          end
        end
        if (frame_err_o) begin
          err_cnt++;
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_err: frame_err_o with nothing expected");
          end else begin
            e = sb.pop_front();
            if (e.err !== 1'b1 || rx_byte_o !== e.b) begin
              bad++;
              $display("FAIL frame_err: got err byte %h, want err=%0b byte %h", rx_byte_o, e.err, e.b);
            end
          end
        end
        if (!rx_dv_o) begin
          total++;
          if (rx_byte_o !== last) begin
            bad++;
            $display("FAIL byte_stable: got %h, held value %h", rx_byte_o, last);
          end
        end
        last = rx_byte_o;
      end
    end
  endtask

  // Caller must be on a negedge; returns on the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
    rx_i = 1'b0;
    repeat (per) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (per) @(negedge clk_i);
    end
    rx_i = stop_bit;
    repeat (per) @(negedge clk_i);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rx_i = 1'b1;
    clks_per_bit_i = 16'd8;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (rx_dv_o !== 1'b0)     begin bad++; $display("FAIL reset_dv: got %b want 0", rx_dv_o); end
    total++; if (rx_byte_o !== 8'h00)  begin bad++; $display("FAIL reset_byte: got %h want 00", rx_byte_o); end
    total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err_o); end
    total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic test_basic();
    dv_cnt = 0; err_cnt = 0;
    clks_per_bit_i = 16'd8;
    sb.push_back('{err: 1'b0, b: 8'hA5});
    send_frame(8'hA5, 1'b1, 8);
    wait_drain(100);
    repeat (8) @(negedge clk_i);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL basic_drain: got %0d pending want 0", sb.size()); end
    total++; if (dv_cnt != 1)    begin bad++; $display("FAIL basic_dv_cnt: got %0d want 1", dv_cnt); end
    total++; if (err_cnt != 0)   begin bad++; $display("FAIL basic_err_cnt: got %0d want 0", err_cnt); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", busy_o); end
    total++; if (rx_byte_o !== 8'hA5) begin bad++; $display("FAIL basic_byte: got %h want a5", rx_byte_o); end
  endtask

  task automatic test_glitch();
    dv_cnt = 0; err_cnt = 0;
    clks_per_bit_i = 16'd16;
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (6) @(negedge clk_i);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL glitch_seen: got busy %b want 1", busy_o); end
    repeat (4) @(negedge clk_i);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL glitch_idle: got busy %b want 0", busy_o); end
    total++; if (dv_cnt + err_cnt != 0) begin bad++; $display("FAIL glitch_pulse: got %0d pulses want 0", dv_cnt + err_cnt); end
    sb.push_back('{err: 1'b0, b: 8'h3C});
    send_frame(8'h3C, 1'b1, 16);
    wait_drain(200);
    repeat (4) @(negedge clk_i);
    total++; if (dv_cnt != 1 || sb.size() != 0) begin bad++; $display("FAIL glitch_next: got dv %0d pending %0d want 1/0", dv_cnt, sb.size()); end
  endtask

  task automatic test_frame_err();
    dv_cnt = 0; err_cnt = 0;
    clks_per_bit_i = 16'd8;
    sb.push_back('{err: 1'b0, b: 8'hA5});
    sb.push_back('{err: 1'b1, b: 8'hA5});
    send_frame(8'hA5, 1'b1, 8);
    send_frame(8'h3C, 1'b0, 8);
    rx_i = 1'b1;
    repeat (24) @(negedge clk_i);
    wait_drain(100);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL ferr_drain: got %0d pending want 0", sb.size()); end
    total++; if (err_cnt != 1)   begin bad++; $display("FAIL ferr_err_cnt: got %0d want 1", err_cnt); end
    total++; if (dv_cnt != 1)    begin bad++; $display("FAIL ferr_dv_cnt: got %0d want 1", dv_cnt); end
    total++; if (rx_byte_o !== 8'hA5) begin bad++; $display("FAIL ferr_byte: got %h want a5", rx_byte_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ferr_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [8];
    logic [63:0] wdata;
    bytes = '{8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    dv_cnt = 0; err_cnt = 0;
    rcv.delete();
    clks_per_bit_i = 16'd8;
    for (int i = 0; i < 8; i++) sb.push_back('{err: 1'b0, b: bytes[i]});
    for (int i = 0; i < 8; i++) send_frame(bytes[i], 1'b1, 8);
    wait_drain(100);
    repeat (4) @(negedge clk_i);
    total++; if (dv_cnt != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", dv_cnt); end
    wdata = '0;
    for (int i = 0; i < rcv.size() && i < 8; i++) wdata[8*i +: 8] = rcv[i];
    total++; if (wdata !== 64'h0000000000000FFF) begin bad++; $display("FAIL b2b_wdata: got %h want 0000000000000fff", wdata); end
  endtask

  task automatic test_clamp_change();
    dv_cnt = 0; err_cnt = 0;
    clks_per_bit_i = 16'd2;
    sb.push_back('{err: 1'b0, b: 8'h5A});
    send_frame(8'h5A, 1'b1, 4);
    repeat (8) @(negedge clk_i);
    total++; if (dv_cnt != 1 || sb.size() != 0) begin bad++; $display("FAIL clamp: got dv %0d pending %0d want 1/0", dv_cnt, sb.size()); end
    clks_per_bit_i = 16'd8;
    sb.push_back('{err: 1'b0, b: 8'hC3});
    sb.push_back('{err: 1'b0, b: 8'h96});
    fork
      send_frame(8'hC3, 1'b1, 8);
      begin
        repeat (30) @(negedge clk_i);
        clks_per_bit_i = 16'd12;
      end
    join
    repeat (12) @(negedge clk_i);
    send_frame(8'h96, 1'b1, 12);
    wait_drain(100);
    repeat (4) @(negedge clk_i);
    total++; if (dv_cnt != 3 || sb.size() != 0) begin bad++; $display("FAIL cpb_change: got dv %0d pending %0d want 3/0", dv_cnt, sb.size()); end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL cpb_change_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] part;
    part = 8'h55;
    dv_cnt = 0; err_cnt = 0;
    clks_per_bit_i = 16'd8;
    sb.push_back('{err: 1'b0, b: 8'h7E});
    send_frame(8'h7E, 1'b1, 8);
    wait_drain(100);
    repeat (4) @(negedge clk_i);
    rx_i = 1'b0;
    repeat (8) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      rx_i = part[i];
      repeat (8) @(negedge clk_i);
    end
    rx_i = part[4];
    repeat (4) @(negedge clk_i);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b want 1", busy_o); end
    rst_ni = 1'b0;
    rx_i = 1'b1;
    @(negedge clk_i);
    total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
    total++; if (rx_byte_o !== 8'h00)  begin bad++; $display("FAIL rmid_byte: got %h want 00", rx_byte_o); end
    total++; if (rx_dv_o !== 1'b0 || frame_err_o !== 1'b0) begin bad++; $display("FAIL rmid_pulse: got dv %b err %b want 0/0", rx_dv_o, frame_err_o); end
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    sb.push_back('{err: 1'b0, b: 8'h81});
    send_frame(8'h81, 1'b1, 8);
    wait_drain(100);
    repeat (4) @(negedge clk_i);
    total++; if (dv_cnt != 2 || sb.size() != 0) begin bad++; $display("FAIL rmid_next: got dv %0d pending %0d want 2/0", dv_cnt, sb.size()); end
    total++; if (rx_byte_o !== 8'h81) begin bad++; $display("FAIL rmid_byte_next: got %h want 81", rx_byte_o); end
  endtask

  initial begin
    total = 0; bad = 0; dv_cnt = 0; err_cnt = 0;
    rx_i = 1'b1;
    clks_per_bit_i = 16'd8;
    rst_ni = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_clamp_change();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL final_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_uart_rx.md
Name: prog_uart_rx

Overview:
- UART receiver for the program-load path: 8N1 serial in, one byte out per frame.
- Sits directly upstream of the programming controller; its rx_dv_o/rx_byte_o drive that controller's rx_dv_i/rx_byte_i.
- Bit period is set at run time in clocks per bit, so the same RTL serves any baud rate/clock pairing.
- Adds start-bit glitch rejection and stop-bit framing check, so a corrupt frame never reaches instruction memory.

Parameters:
- CPB_W, 16, width of clks_per_bit_i and of the internal bit-period counter.
- MIN_CPB, 4, smallest supported bit period; smaller programmed values are clamped up to this.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- rx_i  in  1  raw serial line, asynchronous to clk_i, idles high
- clks_per_bit_i  in  CPB_W  clk_i cycles per UART bit (clk freq / baud)
- rx_dv_o  out  1  one-cycle pulse: rx_byte_o holds a new good byte
- rx_byte_o  out  8  last correctly framed byte, LSB received first
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low, byte discarded
- busy_o  out  1  high while state != IDLE

Behaviour:
- Reset values:
  - rx_dv_o=0, rx_byte_o=8'h00, frame_err_o=0, busy_o=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- Synchronizer:
  - rx_i passes through a 2-flop synchronizer; all sampling uses the synced bit rx_s.
  - 2-cycle input latency.
- Bit period latch:
  - cpb_q <= max(clks_per_bit_i, MIN_CPB), latched on the IDLE->START transition only.
  - A change on clks_per_bit_i mid-frame does not affect the current frame.
- Counters:
  - clk_cnt is CPB_W bits; bit_idx is 3 bits.
  - Compares use full width; no wrap inside a frame.
- States:
  - IDLE: rx_s==0 -> START, clk_cnt=0, latch cpb_q.
  - START:
    - When clk_cnt==(cpb_q-1)>>1 (mid start bit): rx_s==0 -> DATA, clk_cnt=0, bit_idx=0.
    - rx_s==1 there -> IDLE (glitch rejected, no output).
    - Otherwise clk_cnt++.
  - DATA:
    - When clk_cnt==cpb_q-1: shift_reg[bit_idx]<=rx_s, clk_cnt=0.
    - If bit_idx==7 -> STOP, else bit_idx++.
    - Otherwise clk_cnt++.
  - STOP:
    - When clk_cnt==cpb_q-1: rx_s==1 -> rx_byte_o<=shift_reg, rx_dv_o<=1.
    - rx_s==0 -> frame_err_o<=1, rx_byte_o unchanged.
    - Either way -> CLEANUP.
  - CLEANUP: one cycle, pulses deassert, -> IDLE.
    - A line still low in IDLE (break) starts a new frame, which is then checked normally.
- Pulses: rx_dv_o and frame_err_o are each exactly one cycle and never assert together.
- Output stability: rx_byte_o changes only in the cycle rx_dv_o asserts; it is stable at all other times.
- Latency: rx_dv_o asserts 1 cycle after the mid-stop-bit sample point, about 9.5 bit periods + 3 cycles after the start edge at rx_i.
- Back-to-back frames:
  - Minimum supported gap is zero idle bits.
  - The STOP sample at mid-bit plus the 1-cycle CLEANUP leaves half a bit period to detect the next start edge.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded and no pulse is emitted.
- No receive FIFO: the consumer must accept each rx_dv_o pulse. The downstream controller does, as it reacts to rx_dv_i in its RESET/DONE states.

Decomposition:
- Shared package prog_uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_e {IDLE, START, DATA, STOP, CLEANUP}.
  - Constants UART_DATA_BITS=8 and CPB_W.
  - Reusable by a future prog_uart_tx.
- One natural sub-module: sync_2ff (parameterised reset value, set to 1 here). Everything else stays in prog_uart_rx.

Test Plan:
- Frame 0xA5: cpb=8, rx_i idle high -> exactly one rx_dv_o pulse, rx_byte_o=8'hA5, frame_err_o stays 0, busy_o falls after CLEANUP.
- Glitch: cpb=16, rx_i low for 3 cycles then high -> no rx_dv_o, no frame_err_o, FSM back in IDLE within 8 cycles; a following frame 0x3C is received correctly.
- Framing error: cpb=8, send 0xA5 good, then 0x3C with stop bit 0 -> frame_err_o one pulse, no rx_dv_o, rx_byte_o remains 8'hA5.
- Back-to-back, zero idle: cpb=8, bytes FF 0F 00 00 00 00 00 00 -> 8 rx_dv_o pulses in order. Loading this into the downstream controller yields wdata 64'h0000000000000FFF and reset asserted.
- Clamp and mid-frame change: clks_per_bit_i=2 -> frame decoded at 4-cycle bit period. Changing clks_per_bit_i 8->12 during DATA keeps the current byte intact, and the next frame uses 12.
- Reset mid-frame: assert rst_ni low during DATA bit 4 -> all outputs at reset values next edge, no pulse; after release, frame 0x81 received correctly.
